alu_issue_ctrl: RTL and testbench

Multi-cycle issue controller that drives the processor ALU from the initiator side.
- Accepts one ALU operation request per transaction over a valid/ready handshake.
- Reads both source operands from the register file and presents in1/in2/ALUctr/branch to the combinational ALU.
- Captures out/flag, writes the result back, and keeps the architectural flag register.
- Sits between instruction decode and the ALU/register-file datapath.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_req_reg.sv | 24 ++
 rtl/alu_issue_ctrl.sv | 126 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: ALU opcodes, flag bit
// positions and the issue FSM state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_PASS  = 3'b000;
  localparam logic [2:0] ALU_ADD   = 3'b001;
  localparam logic [2:0] ALU_COMP  = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_SHLLV = 3'b101;
  localparam logic [2:0] ALU_SHRLV = 3'b110;
  localparam logic [2:0] ALU_SHRAV = 3'b111;

  // Flag vector layout {carry, zero, sign, overflow}
  localparam int FLG_C = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_S = 1;
  localparam int FLG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_req_reg.sv
// Request capture register: loads the packed request on acceptance and is
// cleared synchronously so an aborted request leaves nothing behind.
module alu_req_reg
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] req_q;

  always_ff @(posedge clk) begin
    if (clr)     req_q <= '0;
    else if (ld) req_q <= d;
  end

  assign q = req_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Four-state issue controller: accept, read operands, execute on the external
// combinational ALU, then write back and pulse the response.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int FLAG_W      = 4,
  parameter int ZERO_REG_RO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_ctr,
  input  logic [REG_AW-1:0] req_rs,
  input  logic [REG_AW-1:0] req_rt,
  input  logic [REG_AW-1:0] req_rd,
  input  logic [DATA_W-1:0] req_imm,
  input  logic              req_use_imm,
  input  logic              req_branch,
  output logic [REG_AW-1:0] rf_ra1,
  output logic [REG_AW-1:0] rf_ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [2:0]        alu_ctr,
  output logic              alu_branch,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [FLAG_W-1:0] alu_flag,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [FLAG_W-1:0] flag_q,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_result
);

  localparam int RW = 3 + 3*REG_AW + DATA_W + 2;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [FLAG_W-1:0]   flag_d;
  logic [RW-1:0]       req_vec, rq_vec;
  logic                accept;

  logic [2:0]          rq_ctr;
  logic [REG_AW-1:0]   rq_rs, rq_rt, rq_rd;
  logic [DATA_W-1:0]   rq_imm;
  logic                rq_use_imm, rq_branch;
  logic                alu_active, wr_ok;

  assign accept  = (state_q == IDLE) && req_valid && !rst;
  assign req_vec = {req_ctr, req_rs, req_rt, req_rd, req_imm, req_use_imm, req_branch};

  alu_req_reg #(.W(RW)) u_req (
    .clk (clk),
    .clr (rst),
    .ld  (accept),
    .d   (req_vec),
    .q   (rq_vec)
  );

  assign {rq_ctr, rq_rs, rq_rt, rq_rd, rq_imm, rq_use_imm, rq_branch} = rq_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op1_q   <= '0;
      op2_q   <= '0;
      res_q   <= '0;
      flag_q  <= '0;
    end else begin
      state_q <= state_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      res_q   <= res_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    res_d   = res_q;
    flag_d  = flag_q;
    case (state_q)
      IDLE: if (req_valid) state_d = READ;
      READ: begin
        op1_d   = rf_rd1;
        op2_d   = rq_use_imm ? rq_imm : rf_rd2;
        state_d = EXEC;
      end
      EXEC: begin
        res_d   = alu_out;
        flag_d  = alu_flag;
        state_d = WB;
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read addresses come straight from the request in the accept cycle so the
  // synchronous register file returns data during READ.
  assign rf_ra1 = accept ? req_rs : rq_rs;
  assign rf_ra2 = accept ? req_rt : rq_rt;

  assign alu_active = (state_q == EXEC) || (state_q == WB);
  assign alu_in1    = op1_q;
  assign alu_in2    = op2_q;
  assign alu_ctr    = alu_active ? rq_ctr : ALU_PASS;
  assign alu_branch = alu_active && rq_branch;

  assign wr_ok      = !rq_branch && !((ZERO_REG_RO != 0) && (rq_rd == '0));
  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == WB);
  assign rf_we      = (state_q == WB) && wr_ok;
  assign rf_wa      = rq_rd;
  assign rf_wd      = res_q;
  assign rsp_result = res_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural register file and ALU around the DUT,
// a per-transaction reference model, directed cases and randomized traffic.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [2:0]  req_ctr;
  logic [4:0]  req_rs, req_rt, req_rd;
  logic [31:0] req_imm;
  logic        req_use_imm, req_branch;
  logic [4:0]  rf_ra1, rf_ra2;
  logic [31:0] rf_rd1, rf_rd2;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [2:0]  alu_ctr;
  logic        alu_branch;
  logic [3:0]  alu_flag;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [3:0]  flag_q;
  logic        rsp_valid;
  logic [31:0] rsp_result;

  alu_issue_ctrl #(.DATA_W(32), .REG_AW(5), .FLAG_W(4), .ZERO_REG_RO(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_ctr(req_ctr), .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_imm(req_imm), .req_use_imm(req_use_imm), .req_branch(req_branch),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctr(alu_ctr), .alu_branch(alu_branch),
    .alu_out(alu_out), .alu_flag(alu_flag), .rf_we(rf_we), .rf_wa(rf_wa),
    .rf_wd(rf_wd), .flag_q(flag_q), .rsp_valid(rsp_valid), .rsp_result(rsp_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    case (i)
      0:       return 32'd0;
      1:       return 32'd10;
      2:       return 32'd12;
      6:       return 32'd31;
      7:       return 32'd5;
      default: return (i * 32'h9E3779B1) ^ 32'h0F0F1234;
    endcase
  endfunction

  // ALU behaviour: returns {C, Z, S, V, out}
  function automatic logic [35:0] alu_f(input logic [2:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] o;
    logic        cy, v;
    cy = 1'b0; v = 1'b0; o = 32'd0;
    case (c)
      3'd0: o = a;
      3'd1: begin
        s = {1'b0, a} + {1'b0, b}; o = s[31:0]; cy = s[32];
        v = (a[31] == b[31]) && (o[31] != a[31]);
      end
      3'd2: begin
        s = {1'b0, a} - {1'b0, b}; o = s[31:0]; cy = s[32];
        v = (a[31] != b[31]) && (o[31] != a[31]);
      end
      3'd3: o = a & b;
      3'd4: o = a ^ b;
      3'd5: o = a << b[4:0];
      3'd6: o = a >> b[4:0];
      default: o = $unsigned($signed(a) >>> b[4:0]);
    endcase
    return {cy, (o == 32'd0), o[31], v, o};
  endfunction

  // Environment: combinational ALU and write-before-read register file
  always_comb {alu_flag, alu_out} = alu_f(alu_ctr, alu_in1, alu_in2);

  logic [31:0] erf [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) erf[i] <= init_val(i);
    end else if (rf_we) begin
      erf[rf_wa] <= rf_wd;
    end
    rf_rd1 <= (rf_we && !rst && rf_wa == rf_ra1) ? rf_wd : erf[rf_ra1];
    rf_rd2 <= (rf_we && !rst && rf_wa == rf_ra2) ? rf_wd : erf[rf_ra2];
  end

  // Reference model: one outstanding transaction, outcome computed at acceptance
  logic [31:0] mrf [32];
  bit          pend = 0;
  int          pa;
  logic [2:0]  t_ctr;
  logic        t_br, t_we;
  logic [4:0]  t_rd;
  logic [31:0] t_op1, t_op2, t_res;
  logic [3:0]  t_flag;
  logic [3:0]  mflag = 4'd0;
  int          rsp_log [$];

  always @(negedge clk) begin
    if (rst) begin
      pend  = 0;
      mflag = 4'd0;
      for (int i = 0; i < 32; i++) mrf[i] = init_val(i);
    end else begin
      if (pend && cyc == pa + 4) pend = 0;
      if (pend && cyc == pa + 3) mflag = t_flag;
      chk("req_ready", req_ready, !pend);
      chk("rsp_valid", rsp_valid, pend && cyc == pa + 3);
      chk("rf_we", rf_we, pend && cyc == pa + 3 && t_we);
      if (pend && cyc == pa + 3) begin
        chk("rf_wa", rf_wa, t_rd);
        chk("rf_wd", rf_wd, t_res);
        chk("rsp_result", rsp_result, t_res);
      end
      chk("flag_q", flag_q, mflag);
      if (pend && cyc >= pa + 2) begin
        chk("alu_ctr", alu_ctr, t_ctr);
        chk("alu_branch", alu_branch, t_br);
        chk("alu_in1", alu_in1, t_op1);
        chk("alu_in2", alu_in2, t_op2);
      end else begin
        chk("alu_ctr_idle", alu_ctr, 3'b000);
        chk("alu_branch_idle", alu_branch, 1'b0);
      end
      if (rsp_valid) rsp_log.push_back(cyc);
      if (!pend && req_valid) begin
        chk("rf_ra1", rf_ra1, req_rs);
        chk("rf_ra2", rf_ra2, req_rt);
        pend   = 1;
        pa     = cyc;
        t_ctr  = req_ctr;
        t_br   = req_branch;
        t_rd   = req_rd;
        t_op1  = mrf[req_rs];
        t_op2  = req_use_imm ? req_imm : mrf[req_rt];
        {t_flag, t_res} = alu_f(t_ctr, t_op1, t_op2);
        t_we   = !req_branch && req_rd != 5'd0;
        if (t_we) mrf[req_rd] = t_res;
      end
    end
  end

  task automatic issue(input logic [2:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] imm, input logic ui,
                       input logic br, output int acc);
    req_valid = 1'b1; req_ctr = c; req_rs = rs; req_rt = rt; req_rd = rd;
    req_imm = imm; req_use_imm = ui; req_branch = br;
    acc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready) begin acc = cyc; break; end
    end
    if (acc < 0) chk("accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Waits for the response pulse; samples alu_in2 during EXEC on the way
  task automatic wait_rsp(input int acc, output int rc, output logic [31:0] e_in2);
    rc = -1; e_in2 = 32'd0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0 || cyc <= acc + 1) @(negedge clk);
      if (cyc == acc + 2) e_in2 = alu_in2;
      if (rsp_valid) begin rc = cyc; break; end
    end
    if (rc < 0) chk("rsp_timeout", 64'd0, 64'd1);
  endtask

  int acc, acc2, rc, nbusy;
  logic [31:0] e2;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_ctr = 3'd0; req_rs = 5'd0; req_rt = 5'd0;
    req_rd = 5'd0; req_imm = 32'd0; req_use_imm = 1'b0; req_branch = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", req_ready, 1'b1);
    chk("reset_flag", flag_q, 4'd0);
    chk("reset_we", rf_we, 1'b0);
    chk("reset_rsp", rsp_valid, 1'b0);
    chk("reset_wd", rf_wd, 32'd0);
    @(posedge clk); #1;

    // ADD r1 + r2 -> r3
    issue(3'b001, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 1'b0, acc);
    wait_rsp(acc, rc, e2);
    chk("add_latency", rc - acc, 3);
    chk("add_we", rf_we, 1'b1);
    chk("add_wa", rf_wa, 5'd3);
    chk("add_wd", rf_wd, 32'd22);
    chk("add_result", rsp_result, 32'd22);
    chk("add_zero", flag_q[2], 1'b0);
    @(posedge clk); #1;

    // XOR r6 ^ imm 127 -> r4
    issue(3'b100, 5'd6, 5'd0, 5'd4, 32'd127, 1'b1, 1'b0, acc);
    wait_rsp(acc, rc, e2);
    chk("xor_exec_in2", e2, 32'd127);
    chk("xor_wd", rf_wd, 32'h60);
    @(posedge clk); #1;

    // SHLLV r6 << 31 -> r5
    issue(3'b101, 5'd6, 5'd0, 5'd5, 32'd127, 1'b1, 1'b0, acc);
    wait_rsp(acc, rc, e2);
    chk("shl_wd", rf_wd, 32'h80000000);
    chk("shl_sign", flag_q[1], 1'b1);
    chk("shl_zero", flag_q[2], 1'b0);
    @(posedge clk); #1;

    // Branch: 5 + (-5), flags only
    issue(3'b001, 5'd7, 5'd0, 5'd8, 32'hFFFFFFFB, 1'b1, 1'b1, acc);
    wait_rsp(acc, rc, e2);
    chk("br_rsp", rsp_valid, 1'b1);
    chk("br_we", rf_we, 1'b0);
    chk("br_zero", flag_q[2], 1'b1);
    @(posedge clk); #1;

    // Reset during EXEC aborts the request
    issue(3'b001, 5'd1, 5'd2, 5'd9, 32'd0, 1'b0, 1'b0, acc);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", req_ready, 1'b1);
    chk("abort_flag", flag_q, 4'd0);
    nbusy = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      if (rsp_valid || rf_we) nbusy++;
    end
    chk("abort_no_pulse", nbusy, 0);
    @(posedge clk); #1;

    // rd = 0 write suppressed
    issue(3'b001, 5'd1, 5'd2, 5'd0, 32'd0, 1'b0, 1'b0, acc);
    wait_rsp(acc, rc, e2);
    chk("r0_we", rf_we, 1'b0);
    chk("r0_result", rsp_result, 32'd22);
    @(posedge clk); #1;

    // Back-to-back with req_valid held high
    rsp_log.delete();
    req_valid = 1'b1; req_ctr = 3'b011; req_rs = 5'd1; req_rt = 5'd2; req_rd = 5'd10;
    req_use_imm = 1'b0; req_branch = 1'b0;
    acc = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready) begin acc = cyc; break; end
    end
    @(posedge clk); #1;
    req_ctr = 3'b010; req_rd = 5'd11;
    nbusy = 0; acc2 = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready) begin acc2 = cyc; break; end
      nbusy++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("b2b_busy", nbusy, 3);
    chk("b2b_accept_gap", acc2 - acc, 4);
    for (int k = 0; k < 12 && rsp_log.size() < 2; k++) @(negedge clk);
    if (rsp_log.size() >= 2) chk("b2b_rsp_gap", rsp_log[1] - rsp_log[0], 4);
    else chk("b2b_rsp_count", rsp_log.size(), 2);
    @(posedge clk); #1;

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      issue(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), acc);
      if ($urandom_range(0, 19) == 0) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
      end
    end
    repeat (6) @(posedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
